// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Issue controller in front of the 8-bit ALU. It accepts one
//                instruction per valid/ready handshake and reads operands from
//                a small register file. It presents registered operands and
//                the select to the ALU, then captures the result and flags.
//                It writes the result back and pulses a one-cycle strobe when
//                the instruction completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction handshake
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [1:0]        instr_rd,
    input  logic [1:0]        instr_rs,
    input  logic [1:0]        instr_rt,
    input  logic [DATA_W-1:0] instr_imm,
    // ALU side
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_z,
    // completion report
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_zero,
    output logic              res_err,
    // debug read port
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // opcode encodings understood by the controller
    localparam logic [3:0] c_OP_LDI = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_NOR = 4'b0011;
    localparam logic [3:0] c_OP_EQ  = 4'b0110;
    localparam logic [3:0] c_OP_LT  = 4'b1000;
    localparam logic [3:0] c_OP_SHL = 4'b1011;
    localparam logic [3:0] c_OP_SHR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [1:0]        r_rd;
    logic [DATA_W-1:0] r_imm;
    logic              w_op_is_alu;

    // ready is a pure decode of the state, so it reads 1 while reset holds IDLE
    assign instr_ready = (r_state == S_IDLE);

    // debug port looks straight into the register file
    assign dbg_data = r_regs[dbg_addr];

    // classify the latched opcode; alu_sel doubles as the latched opcode copy
    always_comb begin
        w_op_is_alu = 1'b0;
        case (alu_sel)
            c_OP_ADD, c_OP_SUB, c_OP_NOR, c_OP_EQ,
            c_OP_LT,  c_OP_SHL, c_OP_SHR: w_op_is_alu = 1'b1;
            default:                      w_op_is_alu = 1'b0;
        endcase
    end

    // issue FSM with register file, ALU operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rd      <= '0;
            r_imm     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        // operands are read here, so rd == rs/rt sees the old value
                        alu_a   <= r_regs[instr_rs];
                        alu_b   <= r_regs[instr_rt];
                        alu_sel <= instr_op;
                        r_rd    <= instr_rd;
                        r_imm   <= instr_imm;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_sel == c_OP_LDI) begin
                        r_regs[r_rd] <= r_imm;
                        res_data     <= r_imm;
                        res_carry    <= 1'b0;
                        res_zero     <= 1'b0;
                        res_err      <= 1'b0;
                    end else if (w_op_is_alu) begin
                        r_regs[r_rd] <= alu_out;
                        res_data     <= alu_out;
                        res_carry    <= alu_carry;
                        res_zero     <= alu_z;
                        res_err      <= 1'b0;
                    end else begin
                        // unsupported opcode: report, but leave the register file alone
                        res_data     <= '0;
                        res_carry    <= 1'b0;
                        res_zero     <= 1'b0;
                        res_err      <= 1'b1;
                    end
                    res_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    // strobe and error flag are one-shot; data and flags hold
                    res_valid <= 1'b0;
                    res_err   <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Scoreboard bench for alu_issue_ctrl with a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic [1:0] instr_rt;
    logic [7:0] instr_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_z;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       res_err;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    typedef struct {
        logic [7:0] data;
        logic       c;
        logic       z;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m [4];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [8:0] w_alu;

    alu_issue_ctrl #(.DATA_W(8), .NREGS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_rt    (instr_rt),
        .instr_imm   (instr_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .alu_z       (alu_z),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .res_zero    (res_zero),
        .res_err     (res_err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural ALU: returns {carry, result}; non-ALU codes give junk
    function automatic logic [8:0] alu_model(input logic [3:0] sel,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        logic [8:0] r;
        logic [7:0] d;
        d = a - b;
        case (sel)
            4'b0001: r = {1'b0, a} + {1'b0, b};
            4'b0010: r = {(a >= b), d};
            4'b0011: r = {1'b0, ~(a | b)};
            4'b0110: r = {1'b0, 7'd0, (a == b)};
            4'b1000: r = {1'b0, 7'd0, (a < b)};
            4'b1011: r = {a[7], a[6:0], 1'b0};
            4'b1100: r = {a[0], 1'b0, a[7:1]};
            default: r = 9'h05A;
        endcase
        return r;
    endfunction

    assign w_alu     = alu_model(alu_sel, alu_a, alu_b);
    assign alu_out   = w_alu[7:0];
    assign alu_carry = w_alu[8];
    assign alu_z     = (w_alu[7:0] == 8'd0);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_dbg(input logic [1:0] a, input string tag);
        dbg_addr = a;
        #1;
        check(tag, {24'd0, dbg_data}, {24'd0, m[a]});
    endtask

    // wait (bounded) for a negedge where the controller is ready
    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", instr_ready, 1);
    endtask

    // build the expected completion and update the register model
    task automatic predict(input logic [3:0] op, input logic [1:0] rd,
                           input logic [1:0] rs, input logic [1:0] rt,
                           input logic [7:0] imm, output exp_t e);
        logic [8:0] r;
        e.cyc = cyc;
        e.c   = 1'b0;
        e.z   = 1'b0;
        e.err = 1'b0;
        case (op)
            4'b0000: begin
                e.data = imm;
                m[rd]  = imm;
            end
            4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b1000, 4'b1011, 4'b1100: begin
                r      = alu_model(op, m[rs], m[rt]);
                e.data = r[7:0];
                e.c    = r[8];
                e.z    = (r[7:0] == 8'd0);
                m[rd]  = r[7:0];
            end
            default: begin
                e.data = 8'd0;
                e.err  = 1'b1;
            end
        endcase
    endtask

    // one full instruction: accept, ISSUE, DONE, back in IDLE
    task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [1:0] rt,
                         input logic [7:0] imm);
        exp_t       e;
        logic [7:0] ea;
        logic [7:0] eb;
        wait_ready();
        ea = m[rs];
        eb = m[rt];
        predict(op, rd, rs, rt, imm, e);
        instr_op    = op;
        instr_rd    = rd;
        instr_rs    = rs;
        instr_rt    = rt;
        instr_imm   = imm;
        instr_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0;
        check("issue_ready", instr_ready, 0);
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_sel", alu_sel, op);
        @(negedge clk);
        check("done_valid", res_valid, 1);
        @(negedge clk);
        check("idle_valid", res_valid, 0);
        check("idle_err", res_err, 0);
        check("idle_ready", instr_ready, 1);
        check("hold_data", res_data, e.data);
        check_dbg(rd, "dbg_rd");
    endtask

    // scoreboard: pop and compare on each completion strobe
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", res_valid, 0);
            end else begin
                e = sb.pop_front();
                check("res_data", res_data, e.data);
                check("res_carry", res_carry, e.c);
                check("res_zero", res_zero, e.z);
                check("res_err", res_err, e.err);
                check("latency", cyc - e.cyc, 2);
            end
        end
    end

    initial begin
        exp_t e;
        int   last;
        for (int i = 0; i < 4; i++) m[i] = 8'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = 4'd0;
        instr_rd    = 2'd0;
        instr_rs    = 2'd0;
        instr_rt    = 2'd0;
        instr_imm   = 8'd0;
        dbg_addr    = 2'd0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_post", instr_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_res_data", res_data, 0);
        for (int i = 0; i < 4; i++) check_dbg(i[1:0], "rst_dbg");

        // basic LDI / ADD
        issue(4'b0000, 2'd0, 2'd0, 2'd0, 8'd15);
        issue(4'b0000, 2'd1, 2'd0, 2'd0, 8'd10);
        issue(4'b0001, 2'd2, 2'd0, 2'd1, 8'd0);

        // unsupported opcode to r1, then a valid op clears the error
        issue(4'b0100, 2'd1, 2'd0, 2'd0, 8'd99);
        check_dbg(2'd1, "err_r1_kept");

        // carry and zero cases
        issue(4'b0000, 2'd0, 2'd0, 2'd0, 8'd200);
        issue(4'b0000, 2'd1, 2'd0, 2'd0, 8'd100);
        issue(4'b0001, 2'd3, 2'd0, 2'd1, 8'd0);
        issue(4'b0010, 2'd2, 2'd0, 2'd0, 8'd0);

        // remaining ALU ops, including rd aliased to a source
        issue(4'b0011, 2'd2, 2'd0, 2'd1, 8'd0);
        issue(4'b1011, 2'd0, 2'd0, 2'd1, 8'd0);
        issue(4'b1000, 2'd2, 2'd1, 2'd3, 8'd0);
        issue(4'b0110, 2'd2, 2'd1, 2'd1, 8'd0);
        issue(4'b1100, 2'd3, 2'd3, 2'd0, 8'd0);
        issue(4'b0001, 2'd1, 2'd1, 2'd1, 8'd0);
        issue(4'b0000, 2'd3, 2'd0, 2'd0, 8'd0);

        // instr_valid held high: four LDIs accepted every third edge
        last = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            if (i > 0) check("accept_gap", cyc - last, 3);
            last = cyc;
            predict(4'b0000, i[1:0], 2'd0, 2'd0, 8'(8'h30 + i), e);
            instr_op    = 4'b0000;
            instr_rd    = i[1:0];
            instr_imm   = 8'(8'h30 + i);
            instr_valid = 1'b1;
            sb.push_back(e);
            @(negedge clk);
            check("stream_busy", instr_ready, 0);
            if (i == 3) instr_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("stream_drained", sb.size(), 0);
        for (int i = 0; i < 4; i++) check_dbg(i[1:0], "stream_dbg");

        // reset asserted while an ADD is in ISSUE
        issue(4'b0000, 2'd2, 2'd0, 2'd0, 8'd77);
        wait_ready();
        instr_op    = 4'b0001;
        instr_rd    = 2'd2;
        instr_rs    = 2'd0;
        instr_rt    = 2'd1;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        for (int i = 0; i < 4; i++) m[i] = 8'd0;
        #1;
        check("midrst_ready", instr_ready, 1);
        check("midrst_valid", res_valid, 0);
        check("midrst_alu_a", alu_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_valid", res_valid, 0);
        check("postrst_ready", instr_ready, 1);
        check_dbg(2'd2, "postrst_r2");
        issue(4'b0000, 2'd3, 2'd0, 2'd0, 8'd7);
        issue(4'b0001, 2'd2, 2'd3, 2'd3, 8'd0);
        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
